pixel_writer: RTL and testbench

PIXEL_WRITER -- requirements
Module: pixel_writer

---
 rtl/pixel_writer.sv | 141 ++++++++++++++
 tb/tb_pixel_writer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_writer.sv
// Plots single pixels into a 1 bpp, 16-pixels-per-word SRAM framebuffer by read-modify-write,
// buffering incoming points in a small FIFO; also zeroes the whole framebuffer on request.
module pixel_writer #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              plot,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              clear,
    output logic              busy,
    output logic              clear_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic [15:0]       mem_rdata,
    output logic [2:0]        dbg_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int PIX_W = ADDR_W + 4;
    localparam int WORDS = WIDTH * HEIGHT / 16;
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_RWAIT = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_CLEAR = 3'd4;

    logic [2:0]        r_state;
    logic [9:0]        r_fx [FIFO_DEPTH];
    logic [9:0]        r_fy [FIFO_DEPTH];
    logic [PTR_W:0]    r_wp;
    logic [PTR_W:0]    r_rp;
    logic              r_clr_pend;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_bit;
    logic [15:0]       r_wdata;
    logic              r_clear_done;

    logic              w_full;
    logic              w_empty;
    logic              w_in_range;
    logic              w_push;
    logic              w_pop;
    logic [PIX_W-1:0]  w_pix;
    logic              w_clear_fire;
    logic              w_last;

    assign w_full       = (r_wp - r_rp) == (PTR_W + 1)'(FIFO_DEPTH);
    assign w_empty      = (r_wp == r_rp);
    assign w_in_range   = ({22'd0, x} < 32'(WIDTH)) && ({22'd0, y} < 32'(HEIGHT));
    assign busy         = w_full | (r_state == S_CLEAR) | r_clr_pend;
    assign w_push       = plot & ~busy & w_in_range;
    assign w_pop        = (r_state == S_IDLE) & ~r_clr_pend & ~w_empty;
    assign w_clear_fire = clear & (r_state != S_CLEAR);
    assign w_last       = (r_state == S_CLEAR) & mem_gnt & (r_cnt == LAST_WORD);

    // Linear pixel index of the FIFO head; upper bits form the word address, low nibble the bit.
    assign w_pix = PIX_W'(r_fy[r_rp[PTR_W-1:0]]) * PIX_W'(WIDTH) + PIX_W'(r_fx[r_rp[PTR_W-1:0]]);

    // SRAM handshake: mem_req rises with mem_we/mem_addr/mem_wdata set up and all four stay
    // constant until the cycle mem_gnt is high, which is the cycle the access completes.
    assign mem_req    = (r_state == S_READ) | (r_state == S_WRITE) | (r_state == S_CLEAR);
    assign mem_we     = (r_state == S_WRITE) | (r_state == S_CLEAR);
    assign mem_addr   = (r_state == S_CLEAR) ? r_cnt : r_addr;
    assign mem_wdata  = (r_state == S_WRITE) ? r_wdata : 16'd0;
    assign clear_done = r_clear_done;
    assign dbg_state  = r_state;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fx[r_wp[PTR_W-1:0]] <= x;
            r_fy[r_wp[PTR_W-1:0]] <= y;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_wp         <= '0;
            r_rp         <= '0;
            r_clr_pend   <= 1'b0;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_bit        <= '0;
            r_wdata      <= '0;
            r_clear_done <= 1'b0;
        end else begin
            r_clear_done <= w_last;
            if (w_clear_fire) r_clr_pend <= 1'b1;
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (r_clr_pend) begin
                        r_clr_pend <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= S_CLEAR;
                    end else if (!w_empty) begin
                        r_addr  <= w_pix[PIX_W-1:4];
                        r_bit   <= w_pix[3:0];
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    if (mem_gnt) r_state <= S_RWAIT;
                end
                S_RWAIT: begin
                    r_wdata <= mem_rdata | (16'd1 << r_bit);
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    if (mem_gnt) r_state <= S_IDLE;
                end
                S_CLEAR: begin
                    if (mem_gnt) begin
                        if (r_cnt == LAST_WORD) begin
                            // Points queued before the clear are stale once the screen is blank.
                            r_rp    <= r_wp;
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer: a vector table of single plots plus hand-written
// sequences for latency, backpressure, clear and reset corner cases.
module tb_pixel_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        plot;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        clear;
    logic        busy;
    logic        clear_done;
    logic        mem_req;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_gnt;
    logic [15:0] mem_rdata;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    pixel_writer #(
        .WIDTH(640), .HEIGHT(480), .FIFO_DEPTH(4), .ADDR_W(15)
    ) dut (
        .clk(clk), .reset(reset), .plot(plot), .x(x), .y(y), .clear(clear),
        .busy(busy), .clear_done(clear_done), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        valid;
        logic [14:0] addr;
        logic [15:0] data;
    } vec_t;

    vec_t        vecs[10];
    logic [30:0] exp_q[$];
    logic [30:0] mon_e;
    logic [15:0] mem [0:32767];
    logic [15:0] rdata_r;
    int          n_vec = 0;
    int          n_err = 0;
    int          n_acc = 0;
    int          clr_next = 0;
    int          clr_bad = 0;
    bit          clr_active = 1'b0;

    // SRAM model: reads return data the cycle after the grant.
    always @(posedge clk) begin
        if (mem_req && mem_gnt) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        rdata_r <= mem[mem_addr];
        end
    end
    assign mem_rdata = rdata_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard on granted writes.
    always @(negedge clk) begin
        if (!reset && mem_req && mem_gnt) begin
            n_acc++;
            if (mem_we) begin
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("write", {1'b0, mem_addr, mem_wdata}, {1'b0, mon_e});
                end else if (clr_active) begin
                    if (mem_addr != 15'(clr_next) || mem_wdata != 16'd0) clr_bad++;
                    clr_next++;
                end else begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr %0d data %h, expected no write", mem_addr, mem_wdata);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic plot_point(input logic [9:0] px, input logic [9:0] py);
        int w = 0;
        while (busy && w < 200) begin
            tick();
            w++;
        end
        check("plot_not_busy", {31'd0, busy}, 32'd0);
        plot = 1'b1;
        x = px;
        y = py;
        tick();
        plot = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int w = 0;
        while (exp_q.size() > 0 && w < budget) begin
            tick();
            w++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic watch_clear(input string name, input int reclear_at);
        int w = 0;
        int busy_low = 0;
        int extra = 0;
        int acc0;
        while (!clear_done && w < 25000) begin
            if (!busy) busy_low++;
            tick();
            clear = (w + 1 == reclear_at);
            w++;
        end
        clear = 1'b0;
        check({name, "_done"}, {31'd0, clear_done}, 32'd1);
        check({name, "_busy_low"}, busy_low, 0);
        check({name, "_count"}, clr_next, 19200);
        check({name, "_bad_words"}, clr_bad, 0);
        clr_active = 1'b0;
        acc0 = n_acc;
        tick();
        repeat (20) begin
            if (clear_done) extra++;
            tick();
        end
        check({name, "_single_pulse"}, extra, 0);
        check({name, "_no_late_access"}, n_acc - acc0, 0);
    endtask

    initial begin
        #1_500_000;
        n_err++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        int acc0;
        int busy_seen;
        int bad;

        vecs[0] = '{10'd0,    10'd0,    1'b1, 15'd0,     16'h0001};
        vecs[1] = '{10'd15,   10'd0,    1'b1, 15'd0,     16'h8001};
        vecs[2] = '{10'd82,   10'd0,    1'b1, 15'd5,     16'h8004};
        vecs[3] = '{10'd17,   10'd2,    1'b1, 15'd81,    16'h0002};
        vecs[4] = '{10'd639,  10'd479,  1'b1, 15'd19199, 16'h8000};
        vecs[5] = '{10'd640,  10'd0,    1'b0, 15'd0,     16'h0000};
        vecs[6] = '{10'd0,    10'd480,  1'b0, 15'd0,     16'h0000};
        vecs[7] = '{10'd1023, 10'd1023, 1'b0, 15'd0,     16'h0000};
        vecs[8] = '{10'd300,  10'd100,  1'b1, 15'd4018,  16'h1000};
        vecs[9] = '{10'd5,    10'd1,    1'b1, 15'd40,    16'h0020};

        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        mem[5] = 16'h8000;
        rdata_r = 16'h0000;
        reset = 1'b1;
        plot = 1'b0;
        clear = 1'b0;
        x = '0;
        y = '0;
        mem_gnt = 1'b1;

        // Reset state
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_clear_done", {31'd0, clear_done}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {17'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        check("rst_state", {29'd0, dbg_state}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();

        // Latency: push at edge N, read visible after N+1, write visible after N+3.
        exp_q.push_back({15'd80, 16'h0002});
        plot = 1'b1;
        x = 10'd1;
        y = 10'd2;
        @(posedge clk);
        #1 plot = 1'b0;
        @(negedge clk);
        check("lat_idle_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        check("lat_read", {15'd0, mem_req, mem_we, mem_addr}, {15'd0, 1'b1, 1'b0, 15'd80});
        @(negedge clk);
        check("lat_rwait_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        check("lat_write", {mem_req, mem_addr, mem_wdata}, {1'b1, 15'd80, 16'h0002});
        check("lat_write_we", {31'd0, mem_we}, 32'd1);
        @(negedge clk);
        check("lat_back_idle", {31'd0, mem_req}, 32'd0);
        tick();
        wait_drain("lat_drain", 10);

        // Vector table
        for (int i = 0; i < 10; i++) begin
            acc0 = n_acc;
            if (vecs[i].valid) exp_q.push_back({vecs[i].addr, vecs[i].data});
            plot_point(vecs[i].x, vecs[i].y);
            if (vecs[i].valid) begin
                wait_drain("vec_drain", 20);
            end else begin
                busy_seen = 0;
                repeat (8) begin
                    if (busy) busy_seen++;
                    tick();
                end
                check("discard_busy", busy_seen, 0);
                check("discard_no_access", n_acc - acc0, 0);
            end
        end

        // Backpressure: grant withheld, five points fit (four queued plus one in READ).
        mem_gnt = 1'b0;
        for (int i = 0; i < 6; i++) exp_q.push_back({15'(400 + i), 16'h0001});
        for (int i = 0; i < 5; i++) begin
            check("burst_busy_pre", {31'd0, busy}, 32'd0);
            plot = 1'b1;
            x = 10'(16 * i);
            y = 10'd10;
            tick();
        end
        plot = 1'b0;
        check("burst_busy_full", {31'd0, busy}, 32'd1);
        bad = 0;
        repeat (10) begin
            if (!(mem_req && !mem_we && mem_addr == 15'd400 && busy)) bad++;
            tick();
        end
        check("burst_req_held", bad, 0);
        mem_gnt = 1'b1;
        plot_point(10'd80, 10'd10);
        wait_drain("burst_drain", 60);
        tick();

        // Clear during WRITE with two points still queued.
        exp_q.push_back({15'd800, 16'h0001});
        plot = 1'b1;
        x = 10'd0;  y = 10'd20; tick();
        x = 10'd16; y = 10'd20; tick();
        x = 10'd32; y = 10'd20; tick();
        plot = 1'b0;
        tick();
        check("cdw_in_write", {16'd0, mem_req, mem_we, mem_addr}, {16'd0, 1'b1, 1'b1, 15'd800});
        clr_next = 0;
        clr_bad = 0;
        clr_active = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        watch_clear("cdw", -1);
        check("cdw_queue_empty", exp_q.size(), 0);

        // Clear from IDLE, with a second clear request arriving mid-clear.
        clr_next = 0;
        clr_bad = 0;
        clr_active = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        watch_clear("clr", 100);

        // Reset during READ aborts; the next point runs normally.
        mem_gnt = 1'b0;
        plot_point(10'd10, 10'd40);
        tick();
        check("rst_mid_req_before", {31'd0, mem_req}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_req", {31'd0, mem_req}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        mem_gnt = 1'b1;
        tick();
        exp_q.push_back({15'd1200, 16'h0004});
        plot_point(10'd2, 10'd30);
        wait_drain("post_reset_drain", 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
